// File: rtl/multi_counter_with_strobe.sv
// rtl/multi_counter_with_strobe.sv - bank of independent programmable tick counters with registered strobes
// Each channel counts enable ticks up to a loaded period and strobes one cycle after the terminal tick.
module multi_counter_with_strobe #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] enable,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [CH_BITS-1:0]  load_ch,
  input  logic [WIDTH-1:0]    load_period,
  input  logic                load_oneshot,
  output logic [CHANNELS-1:0] strobe,
  output logic [CHANNELS-1:0] busy,
  output logic                strobe_any
);

  typedef enum logic {IDLE, RUN} ch_state_t;

  ch_state_t           state_q  [CHANNELS];
  ch_state_t           state_d  [CHANNELS];
  logic [WIDTH-1:0]    period_q [CHANNELS];
  logic [WIDTH-1:0]    period_d [CHANNELS];
  logic [WIDTH-1:0]    cnt_q    [CHANNELS];
  logic [WIDTH-1:0]    cnt_d    [CHANNELS];
  logic [CHANNELS-1:0] mode_q;
  logic [CHANNELS-1:0] mode_d;
  logic [CHANNELS-1:0] strobe_d;
  logic                ready_q1;
  logic                load_fire;

  assign load_fire = load_valid && load_ready;

  // A load to a channel takes priority over its tick in the same cycle.
  always_comb begin
    mode_d   = mode_q;
    strobe_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]  = state_q[i];
      period_d[i] = period_q[i];
      cnt_d[i]    = cnt_q[i];
      if (load_fire && (load_ch == CH_BITS'(i))) begin
        cnt_d[i] = WIDTH'(1);
        if (load_period != '0) begin
          period_d[i] = load_period;
          mode_d[i]   = load_oneshot;
          state_d[i]  = RUN;
        end else begin
          state_d[i]  = IDLE;
        end
      end else if ((state_q[i] == RUN) && enable[i]) begin
        if (cnt_q[i] == period_q[i]) begin
          cnt_d[i]    = WIDTH'(1);
          strobe_d[i] = 1'b1;
          if (mode_q[i]) begin
            state_d[i] = IDLE;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= IDLE;
        period_q[i] <= '0;
        cnt_q[i]    <= WIDTH'(1);
      end
      mode_q     <= '0;
      strobe     <= '0;
      strobe_any <= 1'b0;
      ready_q1   <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= state_d[i];
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      mode_q     <= mode_d;
      strobe     <= strobe_d;
      strobe_any <= |strobe_d;
      // Two-stage release keeps load_ready low for two cycles after reset.
      ready_q1   <= 1'b1;
      load_ready <= ready_q1;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      busy[i] = (state_q[i] == RUN);
    end
  end

endmodule

// File: doc/multi_counter_with_strobe.md
MULTI_COUNTER_WITH_STROBE -- requirements
Module: multi_counter_with_strobe

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent counter channels, range 1..16.
REQ-002 Parameter WIDTH, default 16: counter and period width in bits, range 2..32.
REQ-003 Derived localparam CH_BITS = max(1, clog2(CHANNELS)): width of the channel select.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1: sole clock; all state updates on its rising edge.
REQ-006 rst  input  1: synchronous active-high reset.
REQ-007 enable  input  CHANNELS: per-channel count tick, one tick per cycle high.
REQ-008 load_valid  input  1: request to program one channel.
REQ-009 load_ready  output  1: load accepted on a cycle with load_valid && load_ready.
REQ-010 load_ch  input  CH_BITS: target channel of the load.
REQ-011 load_period  input  WIDTH: new period P in enable ticks.
REQ-012 load_oneshot  input  1: 1 = one-shot mode, 0 = periodic mode.
REQ-013 strobe  output  CHANNELS: per-channel registered strobe.
REQ-014 busy  output  CHANNELS: per-channel state == RUN.
REQ-015 strobe_any  output  1: registered OR of the next-cycle strobe vector.

Function
REQ-016 Each channel holds: state {IDLE, RUN}, period register, mode bit, count register cnt (WIDTH bits).
REQ-017 Accepted load with P >= 1: period <= P, mode <= load_oneshot, cnt <= 1, state <= RUN, next cycle.
REQ-018 Accepted load with P == 0: state <= IDLE, cnt <= 1; channel is disabled.
REQ-019 load_ch >= CHANNELS: load accepted, no channel affected.
REQ-020 RUN, enable[i] high, cnt != period: cnt <= cnt + 1, no strobe.
REQ-021 RUN, enable[i] high, cnt == period: strobe[i] high on the next cycle, cnt <= 1.
REQ-022 On the terminal tick, periodic mode stays RUN; one-shot mode goes IDLE.
REQ-023 strobe[i] is high for exactly one cycle per terminal tick; latency from the terminal enable edge is 1 cycle.
REQ-024 P == 1: every enable tick is terminal; back-to-back ticks produce back-to-back strobes.
REQ-025 IDLE: enable[i] is ignored; cnt holds; strobe[i] stays 0.
REQ-026 enable[i] low: cnt and state hold, except when a load targets channel i.
REQ-027 Load to channel i and enable[i] in the same cycle: load wins, the tick is discarded, no strobe.
REQ-028 cnt never exceeds period: max P = 2^WIDTH-1 and no wrap-around is possible.
REQ-029 Channels are fully independent; simultaneous terminal ticks on several channels strobe together.
REQ-030 load_ready is low in the reset cycle and the cycle after, then stays high.
REQ-031 strobe_any is high in the same cycle as any strobe bit.

Reset
REQ-032 With rst high, on the next edge: all channels IDLE, cnt = 1, period = 0, mode = 0.
REQ-033 With rst high, on the next edge: strobe = 0, strobe_any = 0, busy = 0, load_ready = 0.
REQ-034 rst overrides load and enable in the same cycle.
REQ-035 A strobe pending from the pre-reset cycle is suppressed.
REQ-036 Reset mid-count discards the period; the channel requires a new load.

Verification
REQ-037 Load ch0, P = 3, periodic, then enable[0] high continuously -> strobe[0] on cycles 4, 7, 10 after the first tick; busy[0] stays 1.
REQ-038 Load ch1, P = 2, one-shot; 5 ticks -> single strobe[1] one cycle after the 2nd tick; busy[1] = 0 afterwards; no further strobes.
REQ-039 Load ch2, P = 1, enable[2] alternating 1/0 -> strobe[2] mirrors enable[2] delayed by 1 cycle.
REQ-040 ch0 at cnt = P, load ch0 P = 5 with enable[0] high in the same cycle -> no strobe; the next strobe comes after 5 further ticks.
REQ-041 rst asserted while ch3 has cnt = P-1 -> next cycle busy = 0, strobe = 0; enable[3] ticks ignored until reload; load_ready low for 2 cycles.
REQ-042 CHANNELS = 4, WIDTH = 8, P = 255 on all channels, all enables high -> all four strobes together after 255 ticks; strobe_any high in that cycle; cnt never exceeds 255.
